bcd_result_recomplement: RTL and testbench
==========================================

// Module: bcd_result_recomplement
// PURPOSE
//  Post-adder correction stage for the BCD adder/subtractor. Takes the raw
//  multi-digit BCD sum A + 9'sComp(B) and its final carry. Produces a
//  signed-magnitude BCD result.
//  In subtract mode it applies the end-around carry (positive result) or
//  re-complements (negative result). It works digit-serially, LSD first,
//  one digit per clock, with valid/ready handshakes on both sides.
// PARAMETERS
//  DIGITS  3  number of BCD digits in the operand/result (>=1)
// PORTS
//  clk        in   1         system clock; all state updates on rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         raw sum, carry and mode are presented
//  in_ready   out  1         block can accept a new raw sum
//  in_mode    in   1         M: 1 = subtract (correct), 0 = add (pass-through)
//  in_sum     in   4*DIGITS  raw BCD sum digits; [3:0] = LSD
//  in_carry   in   1         decimal carry out of the MSD of the raw sum
//  out_valid  out  1         result is valid and held
//  out_ready  in   1         consumer accepts the result
//  out_mag    out  4*DIGITS  BCD magnitude
//  out_sign   out  1         1 = negative (subtract mode only)
//  out_ovf    out  1         add-mode decimal overflow (= in_carry); 0 in subtract mode
//  out_err    out  1         invalid input digit seen (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: in_ready=0 during reset and 1 the cycle after;
//   out_valid=0; out_mag=0; out_sign=0; out_ovf=0; out_err=0; FSM=IDLE.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&in_ready, capture all inputs into
//    working registers, set digit index=0 and go to RUN.
//  - RUN: process digit[idx] and write it back; idx++.
//    After digit DIGITS-1, go to DONE.
//  - DONE: out_valid=1 with outputs stable. On out_ready, go to IDLE.
//  Latency: accept at cycle T; out_valid first high at T+DIGITS+1.
//   Throughput is one result per DIGITS+2 cycles at best.
//  Per-digit rules (c = running carry):
//  - Mode 0: digit passes unchanged. sign=0, ovf=in_carry.
//  - Mode 1, in_carry=1 (positive): c starts at 1; d' = d + c.
//    If d' == 10 then d' = 0 and c = 1, else c = 0.
//    Carry out of the MSD is discarded. sign=0.
//  - Mode 1, in_carry=0 (negative): d' = 9 - d; sign=1.
//  Negative zero: if the final magnitude is all zeros, force out_sign=0.
//  in_ready is 0 outside IDLE. in_valid is ignored while busy; no queuing.
//  out_valid holds until out_ready; back-pressure has unbounded length.
//  A new input is accepted no earlier than the cycle after the handshake.
//  rst asserted in any state aborts the operation. All outputs return to
//  reset values on the next edge; the partial result is lost.
// CONFIGURATION
//  BCDRC_DIGIT_CHECK_EN defined:
//   - Any captured digit > 9 sets out_err=1 for that result.
//   - The offending digit passes through unmodified.
//   - Carry is cleared at that digit.
//  Not defined: out_err tied 0 and no check logic is built.
//   Digits > 9 give undefined magnitude.
// STRUCTURE
//  Package bcd_pkg holds:
//   - typedef bcd_digit_t (4 bit) and constants BCD_NINE = 4'd9, BCD_TEN = 4'd10;
//   - the rc_state_t enum {IDLE, RUN, DONE}.
//  One sub-module, bcd_digit_fix (combinational), takes d, c, mode and neg.
//   It returns d', c_out and err. It is instantiated once; the FSM and
//   shift/index logic live in the top.
// TESTING (DIGITS=3)
//  1. M=1, sum=533, carry=1 (753-219) -> mag=534, sign=0, out_valid at T+4.
//  2. M=1, sum=465, carry=0 (219-753) -> mag=534, sign=1.
//  3. M=1, sum=999, carry=0 (500-500) -> mag=000, sign=0 (negative zero suppressed).
//  4. M=1, sum=099, carry=1 (100-000) -> ripple gives mag=100, sign=0.
//     Also M=0, sum=072, carry=1 -> mag=072, ovf=1.
//  5. Hold out_ready=0 for 5 cycles after test 1: out_* stable, in_ready=0,
//     in_valid pulses ignored. Assert rst mid-RUN: out_valid=0, FSM=IDLE
//     next cycle.
//  6. With BCDRC_DIGIT_CHECK_EN, sum digit1=4'hC -> out_err=1, digit1 unchanged.
//     Without the macro -> out_err=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD result recomplement stage.
// Digit type, decimal constants and the correction FSM state enum.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;
  localparam bcd_digit_t BCD_TEN  = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rc_state_t;

endpackage

// File: rtl/bcd_digit_fix.sv
// Combinational single-digit correction for the recomplement stage.
// Optional digit check built only with BCDRC_DIGIT_CHECK_EN.
module bcd_digit_fix
  import bcd_pkg::*;
(
  input  bcd_digit_t i_d,
  input  logic       i_c,
  input  logic       i_mode,
  input  logic       i_neg,
  output bcd_digit_t o_d,
  output logic       o_c,
  output logic       o_err
);

  logic [4:0] w_sum;
  logic       w_bad;

  assign w_sum = {1'b0, i_d} + {4'b0000, i_c};

`ifdef BCDRC_DIGIT_CHECK_EN
  assign w_bad = (i_d > BCD_NINE);
`else
  assign w_bad = 1'b0;
`endif

  assign o_err = w_bad;

  // Bad digits and add mode pass through; negatives take 9's complement.
  always_comb begin
    o_d = i_d;
    o_c = 1'b0;
    if (w_bad || !i_mode) begin
      o_d = i_d;
      o_c = 1'b0;
    end else if (i_neg) begin
      o_d = BCD_NINE - i_d;
    end else if (w_sum == {1'b0, BCD_TEN}) begin
      o_d = '0;
      o_c = 1'b1;
    end else begin
      o_d = w_sum[3:0];
    end
  end

endmodule

// File: rtl/bcd_result_recomplement.sv
// Digit-serial post-adder correction to signed-magnitude BCD.
// Digit range check enabled by defining BCDRC_DIGIT_CHECK_EN.
module bcd_result_recomplement
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [4*DIGITS-1:0] in_sum,
  input  logic              in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*DIGITS-1:0] out_mag,
  output logic              out_sign,
  output logic              out_ovf,
  output logic              out_err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  rc_state_t   r_state;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_work;
  logic        r_mode;
  logic        r_cin;
  logic        r_c;
  logic        r_err;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_sign;
  logic        r_ovf;

  bcd_digit_t  w_d;
  bcd_digit_t  w_dout;
  logic        w_cout;
  logic        w_err;
  logic        w_last;
  logic        w_zero;
  logic [W-1:0]  w_work_nxt;

  assign w_d    = r_work[{r_idx, 2'b00} +: 4];
  assign w_last = (r_idx == IW'(DIGITS - 1));
  assign w_zero = (w_work_nxt == '0);

  bcd_digit_fix u_fix (
    .i_d    (w_d),
    .i_c    (r_c),
    .i_mode (r_mode),
    .i_neg  (~r_cin),
    .o_d    (w_dout),
    .o_c    (w_cout),
    .o_err  (w_err)
  );

  // Working word with the current digit replaced by its corrected value.
  always_comb begin
    w_work_nxt = r_work;
    w_work_nxt[{r_idx, 2'b00} +: 4] = w_dout;
  end

  // Capture, per-digit processing and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_work      <= '0;
      r_mode      <= 1'b0;
      r_cin       <= 1'b0;
      r_c         <= 1'b0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (r_in_ready && in_valid) begin
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_idx      <= '0;
            r_work     <= in_sum;
            r_mode     <= in_mode;
            r_cin      <= in_carry;
            r_c        <= in_mode & in_carry;
            r_err      <= 1'b0;
            r_sign     <= 1'b0;
            r_ovf      <= 1'b0;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        RUN: begin
          r_work <= w_work_nxt;
          r_c    <= w_cout;
          r_err  <= r_err | w_err;
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_sign      <= r_mode & ~r_cin & ~w_zero;
            r_ovf       <= ~r_mode & r_cin;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_mag   = r_work;
  assign out_sign  = r_sign;
  assign out_ovf   = r_ovf;
  assign out_err   = r_err;

endmodule

// File: tb/tb_bcd_result_recomplement.sv
// Directed bench for bcd_result_recomplement (DIGITS=3).
// Expected values hand-computed from the decimal arithmetic.
module tb_bcd_result_recomplement;
  import bcd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [11:0] in_sum;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_mag;
  logic        out_sign;
  logic        out_ovf;
  logic        out_err;

  int total = 0;
  int bad = 0;

  bcd_result_recomplement #(.DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_sign  (out_sign),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xact(input string tag, input logic m,
                      input logic [11:0] s, input logic c,
                      input logic [11:0] em, input logic es,
                      input logic eo, input logic ee);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_mode  = m;
    in_sum   = s;
    in_carry = c;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_mag"}, 32'(out_mag), 32'(em));
    chk({tag, "_sign"}, 32'(out_sign), 32'(es));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
    chk({tag, "_err"}, 32'(out_err), 32'(ee));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic exp_err;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_sum    = '0;
    in_carry  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_mag", 32'(out_mag), 32'd0);
    chk("rst_flags", {29'd0, out_sign, out_ovf, out_err}, 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0;
    step();
    chk("post_rst_rdy", 32'(in_ready), 32'd1);

    // 753 - 219
    xact("t1", 1'b1, 12'h533, 1'b1, 12'h534, 1'b0, 1'b0, 1'b0);
    // back-pressure with ignored input pulses
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_mode  = 1'b0;
      in_sum   = 12'h777;
      in_carry = 1'b1;
      step();
      chk("hold_ov", 32'(out_valid), 32'd1);
      chk("hold_mag", 32'(out_mag), 32'h534);
      chk("hold_rdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    drain("t1");
    step();
    chk("noqueue_ov", 32'(out_valid), 32'd0);

    // 219 - 753
    xact("t2", 1'b1, 12'h465, 1'b0, 12'h534, 1'b1, 1'b0, 1'b0);
    drain("t2");
    // 500 - 500, negative zero
    xact("t3", 1'b1, 12'h999, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    drain("t3");
    // 100 - 000, carry ripple
    xact("t4", 1'b1, 12'h099, 1'b1, 12'h100, 1'b0, 1'b0, 1'b0);
    drain("t4");
    // add mode with overflow
    xact("t4a", 1'b0, 12'h072, 1'b1, 12'h072, 1'b0, 1'b1, 1'b0);
    drain("t4a");

`ifdef BCDRC_DIGIT_CHECK_EN
    exp_err = 1'b1;
    // bad middle digit stops the ripple
    xact("t6c", 1'b1, 12'h9C9, 1'b1, 12'h9C0, 1'b0, 1'b0, 1'b1);
    drain("t6c");
`else
    exp_err = 1'b0;
`endif
    xact("t6", 1'b0, 12'h1C2, 1'b0, 12'h1C2, 1'b0, 1'b0, exp_err);
    drain("t6");

    // reset in the middle of RUN
    in_valid = 1'b1;
    in_mode  = 1'b1;
    in_sum   = 12'h533;
    in_carry = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("mid_state", 32'(dut.r_state), 32'(RUN));
    rst = 1'b1;
    step();
    chk("abort_ov", 32'(out_valid), 32'd0);
    chk("abort_state", 32'(dut.r_state), 32'(IDLE));
    chk("abort_mag", 32'(out_mag), 32'd0);
    chk("abort_rdy", 32'(in_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("abort_rdy2", 32'(in_ready), 32'd1);

    xact("t7", 1'b1, 12'h465, 1'b0, 12'h534, 1'b1, 1'b0, 1'b0);
    drain("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
